// File: rtl/snn_noc_pkg.sv
// Shared NoC packet layout, packet type codes and phase encoding for the
// injection path between the memory interface and the NoC.
package snn_noc_pkg;

  localparam int SRC_MSB  = 63;
  localparam int SRC_LSB  = 60;
  localparam int DST_MSB  = 59;
  localparam int DST_LSB  = 56;
  localparam int TYPE_MSB = 55;
  localparam int TYPE_LSB = 54;

  localparam logic [1:0] INPUT_T  = 2'b00;
  localparam logic [1:0] KERNEL_T = 2'b01;
  localparam logic [1:0] OUTPUT_T = 2'b11;

  localparam logic [3:0] PE_ADDR_MEM  = 4'h0;
  localparam logic [3:0] PE_ADDR_NOC  = 4'h1;
  localparam logic [3:0] PE_ADDR_BCST = 4'hF;

  typedef enum logic {
    LOAD_FILT = 1'b0,
    STREAM    = 1'b1
  } phase_e;

  typedef enum logic {
    SRC_FLT = 1'b0,
    SRC_IFM = 1'b1
  } src_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock packet FIFO with a fall-through head and a registered occupancy
// count; the owner derives ready/empty from count_o.
module noc_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (count_q != (AW+1)'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/noc_inject_arbiter.sv
// NoC injection stage: buffers the filter and ifmap streams, injects all kernel
// packets first, then round-robins both sources onto one registered NoC port.
module noc_inject_arbiter
  import snn_noc_pkg::*;
#(
  parameter int WIDTH_NOC        = 64,
  parameter int FIFO_DEPTH       = 4,
  parameter int NUM_FILTERS      = 5,
  parameter int IFMAP_PKTS_PER_T = 25,
  parameter int T_WIDTH          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flt_valid,
  output logic                 flt_ready,
  input  logic [WIDTH_NOC-1:0] flt_data,
  input  logic                 ifm_valid,
  output logic                 ifm_ready,
  input  logic [WIDTH_NOC-1:0] ifm_data,
  output logic                 noc_valid,
  input  logic                 noc_ready,
  output logic [WIDTH_NOC-1:0] noc_data,
  output logic                 filters_loaded,
  output logic                 step_done,
  output logic [T_WIDTH-1:0]   step_cnt,
  output logic                 type_err,
  output phase_e               phase_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = $clog2(NUM_FILTERS + 1);
  localparam int IW = $clog2(IFMAP_PKTS_PER_T + 1);

  // Valid/ready: a transfer happens on a posedge where valid && ready. Input
  // ready comes from the registered FIFO count only; the output register
  // reloads when it is empty or the NoC takes the current packet.
  logic [WIDTH_NOC-1:0] flt_head, ifm_head;
  logic [CW-1:0]        flt_count, ifm_count;
  logic                 flt_push, ifm_push, flt_pop, ifm_pop;
  logic                 flt_req, ifm_req, out_free, gnt_valid;
  src_e                 gnt_src;

  phase_e               phase_q, phase_d;
  src_e                 rr_q, rr_d;
  logic [FW-1:0]        flt_cnt_q, flt_cnt_d;
  logic [IW-1:0]        ifm_cnt_q, ifm_cnt_d;
  logic [T_WIDTH-1:0]   step_cnt_q, step_cnt_d;
  logic                 step_done_q, step_done_d;
  logic                 type_err_q, type_err_d;
  logic                 noc_valid_q, noc_valid_d;
  logic [WIDTH_NOC-1:0] noc_data_q, noc_data_d;

  assign flt_ready = (flt_count < CW'(FIFO_DEPTH));
  assign ifm_ready = (ifm_count < CW'(FIFO_DEPTH));
  assign flt_push  = flt_valid && flt_ready;
  assign ifm_push  = ifm_valid && ifm_ready;

  noc_sync_fifo #(.WIDTH(WIDTH_NOC), .DEPTH(FIFO_DEPTH)) u_flt_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(flt_push), .data_i(flt_data),
    .pop_i(flt_pop), .head_o(flt_head), .count_o(flt_count)
  );

  noc_sync_fifo #(.WIDTH(WIDTH_NOC), .DEPTH(FIFO_DEPTH)) u_ifm_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(ifm_push), .data_i(ifm_data),
    .pop_i(ifm_pop), .head_o(ifm_head), .count_o(ifm_count)
  );

  assign flt_req  = (flt_count != '0);
  assign ifm_req  = (ifm_count != '0) && (phase_q == STREAM);
  assign out_free = !noc_valid_q || noc_ready;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_src   = SRC_FLT;
    if (flt_req && ifm_req) begin
      gnt_valid = 1'b1;
      gnt_src   = rr_q;
    end else if (flt_req) begin
      gnt_valid = 1'b1;
      gnt_src   = SRC_FLT;
    end else if (ifm_req) begin
      gnt_valid = 1'b1;
      gnt_src   = SRC_IFM;
    end
  end

  always_comb begin
    phase_d     = phase_q;
    rr_d        = rr_q;
    flt_cnt_d   = flt_cnt_q;
    ifm_cnt_d   = ifm_cnt_q;
    step_cnt_d  = step_cnt_q;
    step_done_d = 1'b0;
    type_err_d  = type_err_q;
    noc_valid_d = noc_valid_q;
    noc_data_d  = noc_data_q;
    flt_pop     = 1'b0;
    ifm_pop     = 1'b0;
    if (out_free) begin
      noc_valid_d = 1'b0;
      if (gnt_valid) begin
        // A wrong-typed head is dropped but still uses up its source's turn.
        if (phase_q == STREAM) rr_d = (gnt_src == SRC_FLT) ? SRC_IFM : SRC_FLT;
        if (gnt_src == SRC_FLT) begin
          flt_pop = 1'b1;
          if (flt_head[TYPE_MSB:TYPE_LSB] == KERNEL_T) begin
            noc_valid_d = 1'b1;
            noc_data_d  = flt_head;
            if (phase_q == LOAD_FILT) begin
              flt_cnt_d = flt_cnt_q + 1'b1;
              if (flt_cnt_q == FW'(NUM_FILTERS - 1)) phase_d = STREAM;
            end
          end else begin
            type_err_d = 1'b1;
          end
        end else begin
          ifm_pop = 1'b1;
          if (ifm_head[TYPE_MSB:TYPE_LSB] == INPUT_T) begin
            noc_valid_d = 1'b1;
            noc_data_d  = ifm_head;
            if (ifm_cnt_q == IW'(IFMAP_PKTS_PER_T - 1)) begin
              ifm_cnt_d   = '0;
              step_done_d = 1'b1;
              step_cnt_d  = step_cnt_q + T_WIDTH'(1);
            end else begin
              ifm_cnt_d = ifm_cnt_q + 1'b1;
            end
          end else begin
            type_err_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= LOAD_FILT;
      rr_q        <= SRC_FLT;
      flt_cnt_q   <= '0;
      ifm_cnt_q   <= '0;
      step_cnt_q  <= '0;
      step_done_q <= 1'b0;
      type_err_q  <= 1'b0;
      noc_valid_q <= 1'b0;
      noc_data_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      rr_q        <= rr_d;
      flt_cnt_q   <= flt_cnt_d;
      ifm_cnt_q   <= ifm_cnt_d;
      step_cnt_q  <= step_cnt_d;
      step_done_q <= step_done_d;
      type_err_q  <= type_err_d;
      noc_valid_q <= noc_valid_d;
      noc_data_q  <= noc_data_d;
    end
  end

  assign noc_valid      = noc_valid_q;
  assign noc_data       = noc_data_q;
  assign filters_loaded = (phase_q == STREAM);
  assign step_done      = step_done_q;
  assign step_cnt       = step_cnt_q;
  assign type_err       = type_err_q;
  assign phase_o        = phase_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Randomised bench for noc_inject_arbiter: per-source expected queues, a
// packet-level monitor and scenario tasks. T_WIDTH is 2 so the step counter wraps quickly.
`timescale 1ns/1ps
module tb_noc_inject_arbiter;
  import snn_noc_pkg::*;

  localparam int W   = 64;
  localparam int NF  = 5;
  localparam int PPT = 25;
  localparam int TW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flt_valid = 1'b0, ifm_valid = 1'b0, noc_ready = 1'b1;
  logic [W-1:0]  flt_data = '0, ifm_data = '0;
  logic          flt_ready, ifm_ready, noc_valid, filters_loaded, step_done, type_err;
  logic [W-1:0]  noc_data;
  logic [TW-1:0] step_cnt;
  phase_e        phase_o;

  int cmp_cnt = 0, err_cnt = 0, cycle = 0, seq = 0;
  int kernel_seen = 0, ifm_seen = 0, step_pulses = 0, bad_cnt = 0, gap_pct = 0;
  bit flt_fire = 0, ifm_fire = 0, rnd_ready = 0;
  logic [W-1:0] flt_send_q[$], ifm_send_q[$], flt_exp_q[$], ifm_exp_q[$];
  int load_src_q[$], load_cyc_q[$];
  logic prev_valid, prev_ready;
  logic [W-1:0] prev_data;

  noc_inject_arbiter #(.WIDTH_NOC(W), .FIFO_DEPTH(4), .NUM_FILTERS(NF),
                       .IFMAP_PKTS_PER_T(PPT), .T_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .flt_valid(flt_valid), .flt_ready(flt_ready), .flt_data(flt_data),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_data(ifm_data),
    .noc_valid(noc_valid), .noc_ready(noc_ready), .noc_data(noc_data),
    .filters_loaded(filters_loaded), .step_done(step_done), .step_cnt(step_cnt),
    .type_err(type_err), .phase_o(phase_o)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] make_pkt(input logic [1:0] typ);
    logic [21:0] r;
    r = 22'($urandom);
    seq++;
    return {PE_ADDR_MEM, PE_ADDR_NOC, typ, r, 32'(seq)};
  endfunction

  // Record accepted pushes: the transfer happens at the next posedge.
  initial forever begin
    @(negedge clk);
    flt_fire = rst_n && flt_valid && flt_ready;
    ifm_fire = rst_n && ifm_valid && ifm_ready;
    if (flt_fire) begin
      if (flt_data[TYPE_MSB:TYPE_LSB] == KERNEL_T) flt_exp_q.push_back(flt_data);
      else bad_cnt++;
    end
    if (ifm_fire) begin
      if (ifm_data[TYPE_MSB:TYPE_LSB] == INPUT_T) ifm_exp_q.push_back(ifm_data);
      else bad_cnt++;
    end
  end

  // Source drivers: hold valid until accepted, random gaps between packets.
  initial forever begin
    @(posedge clk);
    #1;
    if (flt_fire) begin
      if (flt_send_q.size() > 0) void'(flt_send_q.pop_front());
      flt_valid = 1'b0;
      flt_fire = 1'b0;
    end
    if (ifm_fire) begin
      if (ifm_send_q.size() > 0) void'(ifm_send_q.pop_front());
      ifm_valid = 1'b0;
      ifm_fire = 1'b0;
    end
    if (!flt_valid && flt_send_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      flt_valid = 1'b1;
      flt_data  = flt_send_q[0];
    end
    if (!ifm_valid && ifm_send_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      ifm_valid = 1'b1;
      ifm_data  = ifm_send_q[0];
    end
    if (rnd_ready) noc_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor + scoreboard on every negedge.
  initial begin
    logic         load, exp_step;
    logic [1:0]   typ;
    logic [W-1:0] exp_pkt;
    prev_valid = 1'b0;
    prev_ready = 1'b1;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_ready = 1'b1;
      end else begin
        load = (!prev_valid || prev_ready) && noc_valid;
        exp_step = 1'b0;
        if (prev_valid && !prev_ready) begin
          cmp_cnt++;
          if (noc_valid !== 1'b1 || noc_data !== prev_data) begin
            err_cnt++;
            $display("FAIL hold_stable: got valid=%0b data=%h expected valid=1 data=%h", noc_valid, noc_data, prev_data);
          end
        end
        if (load) begin
          typ = noc_data[TYPE_MSB:TYPE_LSB];
          load_cyc_q.push_back(cycle);
          cmp_cnt++;
          if (typ == KERNEL_T) begin
            load_src_q.push_back(0);
            if (flt_exp_q.size() == 0) begin
              err_cnt++;
              $display("FAIL kernel_unexpected: got %h expected no packet", noc_data);
            end else begin
              exp_pkt = flt_exp_q.pop_front();
              if (noc_data !== exp_pkt) begin
                err_cnt++;
                $display("FAIL kernel_pkt: got %h expected %h", noc_data, exp_pkt);
              end
            end
            kernel_seen++;
          end else if (typ == INPUT_T) begin
            load_src_q.push_back(1);
            if (ifm_exp_q.size() == 0) begin
              err_cnt++;
              $display("FAIL ifmap_unexpected: got %h expected no packet", noc_data);
            end else begin
              exp_pkt = ifm_exp_q.pop_front();
              if (noc_data !== exp_pkt) begin
                err_cnt++;
                $display("FAIL ifmap_pkt: got %h expected %h", noc_data, exp_pkt);
              end
            end
            cmp_cnt++;
            if (kernel_seen < NF) begin
              err_cnt++;
              $display("FAIL ifmap_order: got ifmap after %0d kernels expected >= %0d", kernel_seen, NF);
            end
            if ((ifm_seen % PPT) == PPT - 1) exp_step = 1'b1;
            ifm_seen++;
          end else begin
            load_src_q.push_back(2);
            err_cnt++;
            $display("FAIL injected_type: got %b expected 00 or 01", typ);
          end
        end
        if (step_done === 1'b1) step_pulses++;
        cmp_cnt++;
        if (step_done !== exp_step) begin
          err_cnt++;
          $display("FAIL step_done: got %0b expected %0b", step_done, exp_step);
        end
        cmp_cnt++;
        if (step_cnt !== TW'((ifm_seen / PPT) % (1 << TW))) begin
          err_cnt++;
          $display("FAIL step_cnt: got %0d expected %0d", step_cnt, (ifm_seen / PPT) % (1 << TW));
        end
        cmp_cnt++;
        if (filters_loaded !== (kernel_seen >= NF)) begin
          err_cnt++;
          $display("FAIL filters_loaded: got %0b expected %0b", filters_loaded, kernel_seen >= NF);
        end
        prev_valid = noc_valid;
        prev_ready = noc_ready;
        prev_data  = noc_data;
      end
    end
  end

  // Driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    flt_send_q.delete();
    ifm_send_q.delete();
    flt_exp_q.delete();
    ifm_exp_q.delete();
    flt_valid = 1'b0;
    ifm_valid = 1'b0;
    flt_fire = 1'b0;
    ifm_fire = 1'b0;
    rnd_ready = 1'b0;
    noc_ready = 1'b1;
    gap_pct = 0;
    kernel_seen = 0;
    ifm_seen = 0;
    step_pulses = 0;
    bad_cnt = 0;
    #2;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    rnd_ready = 1'b0;
    noc_ready = 1'b1;
    while ((flt_send_q.size() + ifm_send_q.size() + flt_exp_q.size() + ifm_exp_q.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    wait_cycles(8);
    cmp_cnt++;
    if (n >= budget) begin
      err_cnt++;
      $display("FAIL drain_timeout: got %0d cycles expected < %0d", n, budget);
    end
  endtask

  task automatic test_reset();
    assert_reset();
    cmp_cnt += 7;
    if (noc_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_noc_valid: got %0b expected 0", noc_valid); end
    if (flt_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_flt_ready: got %0b expected 1", flt_ready); end
    if (ifm_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ifm_ready: got %0b expected 1", ifm_ready); end
    if (step_cnt !== '0) begin err_cnt++; $display("FAIL reset_step_cnt: got %0d expected 0", step_cnt); end
    if (type_err !== 1'b0) begin err_cnt++; $display("FAIL reset_type_err: got %0b expected 0", type_err); end
    if (filters_loaded !== 1'b0) begin err_cnt++; $display("FAIL reset_filters_loaded: got %0b expected 0", filters_loaded); end
    if (step_done !== 1'b0) begin err_cnt++; $display("FAIL reset_step_done: got %0b expected 0", step_done); end
    release_reset();
  endtask

  task automatic test_ordering();
    wait_cycles(1);
    load_src_q.delete();
    load_cyc_q.delete();
    for (int i = 0; i < 5; i++) ifm_send_q.push_back(make_pkt(INPUT_T));
    wait_cycles(10);
    cmp_cnt += 2;
    if (noc_valid !== 1'b0) begin err_cnt++; $display("FAIL order_idle_valid: got %0b expected 0", noc_valid); end
    if (ifm_ready !== 1'b0) begin err_cnt++; $display("FAIL order_ifm_full: got %0b expected 0", ifm_ready); end
    for (int i = 0; i < 5; i++) flt_send_q.push_back(make_pkt(KERNEL_T));
    drain(300);
    cmp_cnt++;
    if (load_src_q.size() != 10) begin
      err_cnt++;
      $display("FAIL order_count: got %0d expected 10", load_src_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        cmp_cnt++;
        if (load_src_q[i] != ((i < 5) ? 0 : 1)) begin
          err_cnt++;
          $display("FAIL order_seq: got src %0d at %0d expected %0d", load_src_q[i], i, (i < 5) ? 0 : 1);
        end
      end
    end
    cmp_cnt += 2;
    if (filters_loaded !== 1'b1) begin err_cnt++; $display("FAIL order_loaded: got %0b expected 1", filters_loaded); end
    if (phase_o !== STREAM) begin err_cnt++; $display("FAIL order_phase: got %0d expected %0d", phase_o, STREAM); end
  endtask

  task automatic test_backpressure();
    noc_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      flt_send_q.push_back(make_pkt(KERNEL_T));
      ifm_send_q.push_back(make_pkt(INPUT_T));
    end
    wait_cycles(12);
    cmp_cnt += 3;
    if (flt_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_flt_ready: got %0b expected 0", flt_ready); end
    if (ifm_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_ifm_ready: got %0b expected 0", ifm_ready); end
    if (noc_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_noc_valid: got %0b expected 1", noc_valid); end
    drain(300);
  endtask

  task automatic test_round_robin();
    noc_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      flt_send_q.push_back(make_pkt(KERNEL_T));
      ifm_send_q.push_back(make_pkt(INPUT_T));
    end
    wait_cycles(12);
    cmp_cnt++;
    if (flt_ready !== 1'b0 || ifm_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL rr_full: got %0b%0b expected 00", flt_ready, ifm_ready);
    end
    load_src_q.delete();
    load_cyc_q.delete();
    noc_ready = 1'b1;
    wait_cycles(8);
    cmp_cnt++;
    if (load_src_q.size() < 6) begin
      err_cnt++;
      $display("FAIL rr_count: got %0d expected >= 6", load_src_q.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        cmp_cnt++;
        if (load_src_q[i] == load_src_q[i-1] || load_cyc_q[i] != load_cyc_q[i-1] + 1) begin
          err_cnt++;
          $display("FAIL rr_alternate: got src %0d->%0d cyc %0d->%0d expected alternate at 1/clk",
                   load_src_q[i-1], load_src_q[i], load_cyc_q[i-1], load_cyc_q[i]);
        end
      end
    end
    drain(300);
  endtask

  task automatic test_timestep();
    assert_reset();
    release_reset();
    wait_cycles(1);
    for (int i = 0; i < NF; i++) flt_send_q.push_back(make_pkt(KERNEL_T));
    for (int i = 0; i < PPT; i++) ifm_send_q.push_back(make_pkt(INPUT_T));
    gap_pct = 30;
    rnd_ready = 1'b1;
    wait_cycles(40);
    drain(500);
    cmp_cnt += 2;
    if (step_cnt !== TW'(1)) begin err_cnt++; $display("FAIL ts_step_cnt_1: got %0d expected 1", step_cnt); end
    if (step_pulses != 1) begin err_cnt++; $display("FAIL ts_pulses_1: got %0d expected 1", step_pulses); end
    for (int i = 0; i < 3 * PPT; i++) ifm_send_q.push_back(make_pkt(INPUT_T));
    rnd_ready = 1'b1;
    wait_cycles(60);
    drain(1000);
    cmp_cnt += 2;
    if (step_cnt !== TW'(0)) begin err_cnt++; $display("FAIL ts_step_wrap: got %0d expected 0", step_cnt); end
    if (step_pulses != 4) begin err_cnt++; $display("FAIL ts_pulses_4: got %0d expected 4", step_pulses); end
    gap_pct = 0;
  endtask

  task automatic test_bad_type();
    cmp_cnt++;
    if (type_err !== 1'b0) begin err_cnt++; $display("FAIL bad_pre: got %0b expected 0", type_err); end
    for (int i = 0; i < 12; i++) ifm_send_q.push_back(make_pkt(INPUT_T));
    ifm_send_q.push_back(make_pkt(KERNEL_T));
    for (int i = 0; i < 12; i++) ifm_send_q.push_back(make_pkt(INPUT_T));
    ifm_send_q.push_back(make_pkt(KERNEL_T));
    flt_send_q.push_back(make_pkt(INPUT_T));
    drain(500);
    cmp_cnt += 3;
    if (type_err !== 1'b1) begin err_cnt++; $display("FAIL bad_type_err: got %0b expected 1", type_err); end
    if (step_cnt !== TW'(0)) begin err_cnt++; $display("FAIL bad_no_count: got %0d expected 0", step_cnt); end
    if (step_pulses != 4) begin err_cnt++; $display("FAIL bad_pulses: got %0d expected 4", step_pulses); end
    ifm_send_q.push_back(make_pkt(INPUT_T));
    drain(200);
    cmp_cnt += 2;
    if (step_cnt !== TW'(1)) begin err_cnt++; $display("FAIL bad_step_after: got %0d expected 1", step_cnt); end
    if (type_err !== 1'b1) begin err_cnt++; $display("FAIL bad_sticky: got %0b expected 1", type_err); end
  endtask

  task automatic test_random();
    assert_reset();
    release_reset();
    wait_cycles(1);
    for (int i = 0; i < 60; i++) begin
      ifm_send_q.push_back(make_pkt(($urandom_range(0, 9) == 0) ? KERNEL_T : INPUT_T));
    end
    for (int i = 0; i < 45; i++) begin
      flt_send_q.push_back(make_pkt(($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : KERNEL_T));
    end
    gap_pct = 25;
    rnd_ready = 1'b1;
    wait_cycles(150);
    drain(3000);
    cmp_cnt += 2;
    if (type_err !== (bad_cnt > 0)) begin err_cnt++; $display("FAIL rnd_type_err: got %0b expected %0b", type_err, bad_cnt > 0); end
    if (filters_loaded !== (kernel_seen >= NF)) begin err_cnt++; $display("FAIL rnd_loaded: got %0b expected %0b", filters_loaded, kernel_seen >= NF); end
    gap_pct = 0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) begin
      flt_send_q.push_back(make_pkt(KERNEL_T));
      ifm_send_q.push_back(make_pkt(INPUT_T));
    end
    noc_ready = 1'b0;
    wait_cycles(10);
    test_reset();
    wait_cycles(10);
    cmp_cnt += 3;
    if (noc_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_noc_valid: got %0b expected 0", noc_valid); end
    if (flt_ready !== 1'b1 || ifm_ready !== 1'b1) begin err_cnt++; $display("FAIL mid_ready: got %0b%0b expected 11", flt_ready, ifm_ready); end
    if (phase_o !== LOAD_FILT) begin err_cnt++; $display("FAIL mid_phase: got %0d expected %0d", phase_o, LOAD_FILT); end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_backpressure();
    test_round_robin();
    test_timestep();
    test_bad_type();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
